// File: rtl/rom_bus_master_if.sv
// Multiplexed 4-bit ROM/IO bus pins shared by the bus master and its ROM responders.
interface rom_bus_master_if;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       data_en;
  logic       sync;
  logic       cmd;

  modport master (
    input  data_i,
    output data_o,
    output data_en,
    output sync,
    output cmd
  );

  modport slave (
    output data_i,
    input  data_o,
    input  data_en,
    input  sync,
    input  cmd
  );
endinterface

// File: rtl/rom_bus_master.sv
// CPU-side initiator for the 4-bit ROM/IO bus: subcycle sequencer, nibble-serial fetch,
// opcode capture and SRC / I/O-write issue. Every output is a flop fed from next-state.
module rom_bus_master #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic             clock,
  input  logic             reset,
  rom_bus_master_if.master bus,
  input  logic [11:0]      pc,
  input  logic             src_req,
  input  logic [7:0]       src_data,
  input  logic             io_req,
  input  logic [3:0]       io_data,
  output logic [7:0]       inst,
  output logic             inst_valid,
  output logic             src_done,
  output logic             io_done
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OP_W   = 8;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  subcycle_e         phase, phase_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              src_act, src_act_nxt;
  logic              io_act, io_act_nxt;
  logic [OP_W-1:0]   src_reg, src_reg_nxt;
  logic [NIB_W-1:0]  io_reg, io_reg_nxt;
  logic [OP_W-1:0]   inst_nxt;
  logic [NIB_W-1:0]  data_o_nxt;
  logic              data_en_nxt;
  logic              cmd_nxt;
  logic              sync_nxt;
  logic              inst_valid_nxt;
  logic              src_done_nxt;
  logic              io_done_nxt;

  // State and output registers; reset lands directly in the address phase of RESET_PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase       <= SC_A1;
      addr        <= RESET_PC;
      src_act     <= 1'b0;
      io_act      <= 1'b0;
      src_reg     <= '0;
      io_reg      <= '0;
      inst        <= '0;
      bus.data_o  <= RESET_PC[NIB_W-1:0];
      bus.data_en <= 1'b1;
      bus.cmd     <= 1'b1;
      bus.sync    <= 1'b0;
      inst_valid  <= 1'b0;
      src_done    <= 1'b0;
      io_done     <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      addr        <= addr_nxt;
      src_act     <= src_act_nxt;
      io_act      <= io_act_nxt;
      src_reg     <= src_reg_nxt;
      io_reg      <= io_reg_nxt;
      inst        <= inst_nxt;
      bus.data_o  <= data_o_nxt;
      bus.data_en <= data_en_nxt;
      bus.cmd     <= cmd_nxt;
      bus.sync    <= sync_nxt;
      inst_valid  <= inst_valid_nxt;
      src_done    <= src_done_nxt;
      io_done     <= io_done_nxt;
    end
  end

  // Next-state and output decode; outputs are decoded for the subcycle being entered.
  always_comb begin
    phase_nxt      = subcycle_e'(3'(phase + 3'd1));
    addr_nxt       = addr;
    src_act_nxt    = src_act;
    io_act_nxt     = io_act;
    src_reg_nxt    = src_reg;
    io_reg_nxt     = io_reg;
    inst_nxt       = inst;
    data_o_nxt     = '0;
    data_en_nxt    = 1'b0;
    cmd_nxt        = 1'b1;
    sync_nxt       = 1'b0;
    inst_valid_nxt = 1'b0;
    src_done_nxt   = 1'b0;
    io_done_nxt    = 1'b0;

    // Per-cycle requests are taken only at the edge closing X3; SRC has priority over I/O.
    if (phase == SC_X3) begin
      addr_nxt    = pc;
      src_act_nxt = src_req;
      io_act_nxt  = io_req & ~src_req;
      src_reg_nxt = src_data;
      io_reg_nxt  = io_data;
    end

    if (phase == SC_M1) inst_nxt[7:4] = bus.data_i;
    if (phase == SC_M2) inst_nxt[3:0] = bus.data_i;

    unique case (phase_nxt)
      SC_A1: begin
        data_en_nxt = 1'b1;
        data_o_nxt  = addr_nxt[3:0];
      end
      SC_A2: begin
        data_en_nxt = 1'b1;
        data_o_nxt  = addr_nxt[7:4];
      end
      SC_A3: begin
        data_en_nxt = 1'b1;
        data_o_nxt  = addr_nxt[11:8];
      end
      SC_M1: ;
      SC_M2: begin
        if (io_act_nxt) cmd_nxt = 1'b0;
      end
      SC_X1: begin
        inst_valid_nxt = 1'b1;
      end
      SC_X2: begin
        if (src_act_nxt) begin
          cmd_nxt     = 1'b0;
          data_en_nxt = 1'b1;
          data_o_nxt  = src_reg_nxt[7:4];
        end else if (io_act_nxt) begin
          data_en_nxt = 1'b1;
          data_o_nxt  = io_reg_nxt;
        end
      end
      SC_X3: begin
        sync_nxt     = 1'b1;
        src_done_nxt = src_act_nxt;
        io_done_nxt  = io_act_nxt;
        if (src_act_nxt) begin
          data_en_nxt = 1'b1;
          data_o_nxt  = src_reg_nxt[3:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_bus_master.sv
// Scoreboard bench for rom_bus_master: cycle-level plans expand into per-subcycle expectations
// that a negedge monitor compares; a bench ROM/IO responder answers fetches and I/O writes.
module tb_rom_bus_master;

  localparam logic [11:0] RESET_PC = 12'h000;

  logic        clock;
  logic        reset;
  logic [11:0] pc;
  logic        src_req;
  logic [7:0]  src_data;
  logic        io_req;
  logic [3:0]  io_data;
  logic [7:0]  inst;
  logic        inst_valid;
  logic        src_done;
  logic        io_done;

  rom_bus_master_if bus ();

  rom_bus_master #(.RESET_PC(RESET_PC)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .pc         (pc),
    .src_req    (src_req),
    .src_data   (src_data),
    .io_req     (io_req),
    .io_data    (io_data),
    .inst       (inst),
    .inst_valid (inst_valid),
    .src_done   (src_done),
    .io_done    (io_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] pc;
    logic        sreq;
    logic        ireq;
    logic [7:0]  sd;
    logic [3:0]  id;
  } plan_t;

  typedef struct {
    logic [11:0] addr;
    logic        src;
    logic        io;
    logic [7:0]  sd;
    logic [3:0]  id;
  } cyc_t;

  typedef struct {
    logic       en;
    logic [3:0] d;
    logic       cmd;
    logic       sync;
    logic       iv;
    logic       sdone;
    logic       idone;
    logic       chk_inst;
    logic [7:0] inst;
  } exp_t;

  logic [7:0] rom [4096];
  exp_t       q[$];
  cyc_t       cur;
  logic [7:0] prev_inst;
  logic       mon_en;
  int         vectors;
  int         miscompares;

  // Paired ROM/IO responder, kept in lock-step by its own counter cleared on reset.
  logic [2:0]  rcnt;
  logic [11:0] raddr;
  logic        rsel;
  logic        rarm;
  logic [3:0]  port;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rcnt  <= 3'd0;
      raddr <= 12'h000;
      rsel  <= 1'b0;
      rarm  <= 1'b0;
      port  <= 4'h0;
    end else begin
      rcnt <= 3'(rcnt + 3'd1);
      case (rcnt)
        3'd0: raddr[3:0]  <= bus.data_o;
        3'd1: raddr[7:4]  <= bus.data_o;
        3'd2: raddr[11:8] <= bus.data_o;
        3'd4: rarm <= !bus.cmd && (bus.data_i == 4'h2);
        3'd6: begin
          if (!bus.cmd && bus.data_en) rsel <= (bus.data_o == 4'h0);
          if (rarm && rsel && bus.data_en && bus.cmd) port <= bus.data_o;
          rarm <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.data_i = 4'h0;
    if (rcnt == 3'd3) bus.data_i = rom[raddr][7:4];
    if (rcnt == 3'd4) bus.data_i = rom[raddr][3:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL expect_queue_underflow (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("data_en",    32'(bus.data_en), 32'(e.en));
          check("data_o",     32'(bus.data_o),  32'(e.d));
          check("cmd",        32'(bus.cmd),     32'(e.cmd));
          check("sync",       32'(bus.sync),    32'(e.sync));
          check("inst_valid", 32'(inst_valid),  32'(e.iv));
          check("src_done",   32'(src_done),    32'(e.sdone));
          check("io_done",    32'(io_done),     32'(e.idone));
          if (e.chk_inst) check("inst", 32'(inst), 32'(e.inst));
        end
      end
    end
  end

  function automatic cyc_t derive(input plan_t p);
    cyc_t r;
    r.addr = p.pc;
    r.src  = p.sreq;
    r.io   = p.ireq && !p.sreq;
    r.sd   = p.sd;
    r.id   = p.id;
    return r;
  endfunction

  function automatic plan_t mk(input logic [11:0] a, input logic s, input logic i,
                               input logic [7:0] sd, input logic [3:0] id);
    plan_t p;
    p.pc = a; p.sreq = s; p.ireq = i; p.sd = sd; p.id = id;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    return mk(12'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              8'($urandom), 4'($urandom));
  endfunction

  task automatic apply(input plan_t p);
    pc = p.pc; src_req = p.sreq; io_req = p.ireq; src_data = p.sd; io_data = p.id;
  endtask

  // Expand the current instruction cycle into eight bus expectations.
  task automatic push_cycle();
    exp_t e;
    for (int s = 0; s < 8; s++) begin
      e.en = (s < 3) || (s == 6 && (cur.src || cur.io)) || (s == 7 && cur.src);
      if (s < 3)                   e.d = 4'(cur.addr >> (4 * s));
      else if (s == 6 && cur.src)  e.d = cur.sd[7:4];
      else if (s == 6 && cur.io)   e.d = cur.id;
      else if (s == 7 && cur.src)  e.d = cur.sd[3:0];
      else                         e.d = 4'h0;
      e.cmd      = !((s == 6 && cur.src) || (s == 4 && cur.io));
      e.sync     = (s == 7);
      e.iv       = (s == 5);
      e.sdone    = (s == 7) && cur.src;
      e.idone    = (s == 7) && cur.io;
      e.chk_inst = (s < 4) || (s == 5);
      e.inst     = (s == 5) ? rom[cur.addr] : prev_inst;
      q.push_back(e);
    end
    prev_inst = rom[cur.addr];
  endtask

  // Runs the current cycle; junk requests early in the cycle must be ignored.
  task automatic run_cycle(input plan_t nxt);
    push_cycle();
    apply(rand_plan());
    repeat (3) @(posedge clock);
    #1;
    apply(nxt);
    repeat (5) @(posedge clock);
    #1;
    cur = derive(nxt);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    q.delete();
    #1;
    check("rst_data_en",    32'(bus.data_en), 32'd1);
    check("rst_data_o",     32'(bus.data_o),  32'(RESET_PC[3:0]));
    check("rst_cmd",        32'(bus.cmd),     32'd1);
    check("rst_sync",       32'(bus.sync),    32'd0);
    check("rst_inst",       32'(inst),        32'h00);
    check("rst_inst_valid", 32'(inst_valid),  32'd0);
    check("rst_src_done",   32'(src_done),    32'd0);
    check("rst_io_done",    32'(io_done),     32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b0;
    cur       = derive(mk(RESET_PC, 1'b0, 1'b0, 8'h00, 4'h0));
    prev_inst = 8'h00;
    mon_en    = 1'b1;
  endtask

  initial begin
    plan_t p;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    reset       = 1'b0;
    apply(mk(12'hABC, 1'b0, 1'b0, 8'h00, 4'h0));
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h000] = 8'h5A;
    rom[12'hABC] = 8'hC3;
    rom[12'h123] = 8'hE2;
    rom[12'h201] = 8'hE2;

    #2;
    do_reset();
    run_cycle(mk(12'hABC, 1'b0, 1'b0, 8'h00, 4'h0));  // RESET_PC fetch
    run_cycle(mk(12'hABC, 1'b1, 1'b0, 8'h07, 4'h0));  // ABC fetch
    run_cycle(mk(12'h124, 1'b0, 1'b0, 8'h00, 4'h0));  // SRC 07
    run_cycle(mk(12'h123, 1'b0, 1'b1, 8'h00, 4'h9));  // quiet cycle
    run_cycle(mk(12'h200, 1'b1, 1'b1, 8'h31, 4'h5));  // I/O write 9
    check("io_port", 32'(port), 32'h9);
    run_cycle(mk(12'h201, 1'b0, 1'b1, 8'h00, 4'h5));  // SRC wins over I/O
    run_cycle(rand_plan());                           // held I/O now executes

    for (int n = 0; n < 40; n++) begin
      p = rand_plan();
      if (n == 39) p.sreq = 1'b1;
      run_cycle(p);
    end

    // Abort an SRC cycle in subcycle 6.
    push_cycle();
    repeat (6) @(posedge clock);
    @(negedge clock);
    #1;
    do_reset();
    for (int n = 0; n < 3; n++) run_cycle(rand_plan());

    check("expect_queue_drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
